if_stage_s: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the 5-stage core.

---
 rtl/if_stage_s.sv | 136 +++++++++++++
 tb/tb_if_stage_s.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage_s.sv
// Instruction-fetch stage with IF/ID pipeline register. One fetch outstanding at a time,
// a one-entry skid buffer absorbs a response that lands while the pipeline is stalled.
module if_stage_s #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr
);

  typedef enum logic [1:0] {StReq, StWait, StDrop, StFull} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     skid_q, skid_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;

  logic            load;
  logic [31:0]     load_instr;

  // Fetch FSM and PC sequencing.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    load       = 1'b0;
    load_instr = '0;
    unique case (state_q)
      StReq: begin
        if (flush) begin
          pc_d = branch_target;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (flush) begin
          pc_d    = branch_target;
          state_d = imem_valid ? StReq : StDrop;
        end else if (imem_valid) begin
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = StFull;
          end else begin
            load       = 1'b1;
            load_instr = imem_rdata;
            pc_d       = pc_q + XLEN'(4);
            state_d    = StReq;
          end
        end
      end
      StDrop: begin
        // The response still in flight belongs to the killed path.
        if (flush) begin
          pc_d = branch_target;
        end
        if (imem_valid) begin
          state_d = StReq;
        end
      end
      StFull: begin
        if (flush) begin
          skid_d  = '0;
          pc_d    = branch_target;
          state_d = StReq;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = skid_q;
          pc_d       = pc_q + XLEN'(4);
          state_d    = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // IF/ID register: flush > stall > load > bubble.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
    end else if (stall) begin
      ifid_valid_d = ifid_valid_q;
    end else if (load) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = pc_q;
      ifid_instr_d = load_instr;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      skid_q       <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_q       <= skid_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  // Gated by rst_n so the request drops the instant reset asserts.
  assign imem_req   = rst_n && (state_q == StReq) && !flush;
  assign imem_addr  = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;

endmodule

// File: tb/tb_if_stage_s.sv
// Directed bench for if_stage_s: vector table for stall/flush sequences, hand-written
// sequences for streaming fetch, PC wrap and asynchronous reset.
module tb_if_stage_s;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  // Memory: either a 1-cycle model returning addr as data, or driven by hand.
  logic        auto_en = 1'b0;
  logic        auto_valid;
  logic [31:0] auto_data;
  logic        man_valid = 1'b0;
  logic [31:0] man_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_valid <= 1'b0;
      auto_data  <= '0;
    end else begin
      auto_valid <= auto_en && imem_req;
      auto_data  <= imem_addr;
    end
  end

  assign imem_valid = auto_en ? auto_valid : man_valid;
  assign imem_rdata = auto_en ? auto_data : man_rdata;

  always #5 clk = ~clk;

  if_stage_s dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ifid(input string name, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr);
    check({name, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, v});
    check({name, ".ifid_pc"}, ifid_pc, pc);
    check({name, ".ifid_instr"}, ifid_instr, instr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst.imem_req", {31'd0, imem_req}, 32'd0);
    check("rst.imem_addr", imem_addr, 32'd0);
    check_ifid("rst", 1'b0, 32'd0, Nop);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] bt;
    logic        valid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // stall while waiting, skid buffer, flush into DROP, flush+stall collisions
    vecs[0]  = '{0, 0, 32'h0,   0, 32'h0,        1, 32'h000, 0, 32'h000, Nop};
    vecs[1]  = '{1, 0, 32'h0,   0, 32'h0,        0, 32'h000, 0, 32'h000, Nop};
    vecs[2]  = '{1, 0, 32'h0,   1, 32'hDEADBEEF, 0, 32'h000, 0, 32'h000, Nop};
    vecs[3]  = '{1, 0, 32'h0,   0, 32'h0,        0, 32'h000, 0, 32'h000, Nop};
    vecs[4]  = '{1, 0, 32'h0,   1, 32'h11111111, 0, 32'h000, 0, 32'h000, Nop};
    vecs[5]  = '{0, 0, 32'h0,   0, 32'h0,        0, 32'h000, 0, 32'h000, Nop};
    vecs[6]  = '{0, 0, 32'h0,   0, 32'h0,        1, 32'h004, 1, 32'h000, 32'hDEADBEEF};
    vecs[7]  = '{0, 1, 32'h100, 0, 32'h0,        0, 32'h004, 0, 32'h000, Nop};
    vecs[8]  = '{0, 0, 32'h0,   0, 32'h0,        0, 32'h100, 0, 32'h000, Nop};
    vecs[9]  = '{0, 0, 32'h0,   1, 32'hCAFEF00D, 0, 32'h100, 0, 32'h000, Nop};
    vecs[10] = '{0, 0, 32'h0,   0, 32'h0,        1, 32'h100, 0, 32'h000, Nop};
    vecs[11] = '{0, 0, 32'h0,   1, 32'h00500093, 0, 32'h100, 0, 32'h000, Nop};
    vecs[12] = '{1, 1, 32'h200, 0, 32'h0,        0, 32'h104, 1, 32'h100, 32'h00500093};
    vecs[13] = '{0, 0, 32'h0,   0, 32'h0,        1, 32'h200, 0, 32'h000, Nop};
    vecs[14] = '{1, 1, 32'h300, 1, 32'h12345678, 0, 32'h200, 0, 32'h000, Nop};
    vecs[15] = '{0, 0, 32'h0,   0, 32'h0,        1, 32'h300, 0, 32'h000, Nop};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      stall         = vecs[i].stall;
      flush         = vecs[i].flush;
      branch_target = vecs[i].bt;
      man_valid     = vecs[i].valid;
      man_rdata     = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("vec%0d.imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      check($sformatf("vec%0d.imem_addr", i), imem_addr, vecs[i].exp_addr);
      check_ifid($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_pc, vecs[i].exp_instr);
      @(posedge clk);
      #1;
    end
    stall = 1'b0; flush = 1'b0; man_valid = 1'b0;

    // Streaming with a 1-cycle memory: one instruction every two cycles.
    auto_en = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stream%0d.imem_req", k), {31'd0, imem_req}, 32'd1);
      check($sformatf("stream%0d.imem_addr", k), imem_addr, 32'(4 * k));
      if (k > 0) check_ifid($sformatf("stream%0d", k), 1'b1, 32'(4 * (k - 1)),
                            32'(4 * (k - 1)));
      @(negedge clk);
      check($sformatf("stream%0d.wait_req", k), {31'd0, imem_req}, 32'd0);
      check($sformatf("stream%0d.bubble", k), {31'd0, ifid_valid}, 32'd0);
    end
    @(negedge clk);
    check("stream3.imem_addr", imem_addr, 32'd12);
    check_ifid("stream3", 1'b1, 32'd8, 32'd8);

    // Asynchronous reset while a fetch is outstanding.
    @(posedge clk);
    #2;
    check("arst.pre_addr", imem_addr, 32'd12);
    check("arst.pre_pc", ifid_pc, 32'd8);
    rst_n = 1'b0;
    #1;
    check("arst.imem_req", {31'd0, imem_req}, 32'd0);
    check("arst.imem_addr", imem_addr, 32'd0);
    check_ifid("arst", 1'b0, 32'd0, Nop);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("arst.first_req", {31'd0, imem_req}, 32'd1);
    check("arst.first_addr", imem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_ifid("arst.first_load", 1'b1, 32'd0, 32'd0);

    // PC wrap at the top of the address space.
    do_reset();
    flush = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    check("wrap.flush_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("wrap.req", {31'd0, imem_req}, 32'd1);
    check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    check("wrap.next_req", {31'd0, imem_req}, 32'd1);
    check("wrap.next_addr", imem_addr, 32'd0);
    check_ifid("wrap", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
